// File: rtl/vga_stream_gen_if.sv
// Pixel request bus between the VGA timing pipeline (master) and a fixed-latency framebuffer (slave).
interface vga_stream_gen_if #(
    parameter int X_W    = 11,
    parameter int Y_W    = 10,
    parameter int DATA_W = 12
);
    logic              PIX_REQ;
    logic [X_W-1:0]    PIX_X;
    logic [Y_W-1:0]    PIX_Y;
    logic [DATA_W-1:0] PIX_DATA;

    modport master (output PIX_REQ, PIX_X, PIX_Y, input PIX_DATA);
    modport slave  (input PIX_REQ, PIX_X, PIX_Y, output PIX_DATA);
endinterface

// File: rtl/vga_stream_gen.sv
// Parametrised VGA timing generator with framebuffer request port, latency-matched sync/blank
// pipeline and a built-in pattern source (solid, colour bars, checkerboard).
module vga_stream_gen #(
    parameter int   H_VISIBLE      = 800,
    parameter int   H_FRONT_PORCH  = 56,
    parameter int   H_SYNC_PULSE   = 120,
    parameter int   H_BACK_PORCH   = 64,
    parameter int   V_VISIBLE      = 600,
    parameter int   V_FRONT_PORCH  = 37,
    parameter int   V_SYNC_PULSE   = 6,
    parameter int   V_BACK_PORCH   = 23,
    parameter logic HSYNC_POLARITY = 1'b0,
    parameter logic VSYNC_POLARITY = 1'b0,
    parameter int   COLOR_BITS     = 4,
    parameter int   READ_LATENCY   = 2,
    parameter int   CHECK_LOG2     = 5
) (
    input  logic                    VGA_CLK,
    input  logic                    VGA_RST_N,
    input  logic [1:0]              MODE,
    input  logic [3*COLOR_BITS-1:0] SOLID_RGB,
    vga_stream_gen_if.master        pix,
    output logic [COLOR_BITS-1:0]   VGA_R,
    output logic [COLOR_BITS-1:0]   VGA_G,
    output logic [COLOR_BITS-1:0]   VGA_B,
    output logic                    VGA_HS,
    output logic                    VGA_VS,
    output logic                    FRAME_START,
    output logic                    LINE_START
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int CB      = COLOR_BITS;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [31:0] H_VIS_END  = 32'(H_VISIBLE);
    localparam logic [31:0] H_SYNC_BEG = 32'(H_VISIBLE + H_FRONT_PORCH);
    localparam logic [31:0] H_SYNC_END = 32'(H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [31:0] V_VIS_END  = 32'(V_VISIBLE);
    localparam logic [31:0] V_SYNC_BEG = 32'(V_VISIBLE + V_FRONT_PORCH);
    localparam logic [31:0] V_SYNC_END = 32'(V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE);

    // Bars are tracked with a per-line sub-counter so no divider is needed.
    localparam int BAR_W = (H_VISIBLE >= 8) ? H_VISIBLE / 8 : 1;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BW-1:0] BAR_SUB_LAST = BW'(BAR_W - 1);

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       vis;
        logic       hc;
        logic       vc;
        logic [2:0] bar;
        logic       h0;
        logic       v0;
        logic [1:0] mode;
    } tap_t;

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [BW-1:0] bar_sub;
    logic [2:0]    bar_idx;
    logic [1:0]    mode_latched;
    logic [31:0]   h_ext;
    logic [31:0]   v_ext;
    tap_t          stage0;
    tap_t          dly [READ_LATENCY];
    tap_t          last;
    logic [2:0]    bar_bits;
    logic [3*CB-1:0] color;

    assign h_ext = 32'(h);
    assign v_ext = 32'(v);
    assign last  = dly[READ_LATENCY-1];

    assign pix.PIX_X   = h;
    assign pix.PIX_Y   = v;
    assign pix.PIX_REQ = VGA_RST_N && stage0.vis && (mode_latched == 2'd0);

    always_ff @(posedge VGA_CLK) begin
        if (!VGA_RST_N) begin
            h            <= '0;
            v            <= '0;
            bar_sub      <= '0;
            bar_idx      <= '0;
            mode_latched <= MODE;
        end else if (h == H_LAST) begin
            h       <= '0;
            bar_sub <= '0;
            bar_idx <= '0;
            if (v == V_LAST) begin
                v            <= '0;
                mode_latched <= MODE;
            end else begin
                v <= v + 1'b1;
            end
        end else begin
            h <= h + 1'b1;
            if (bar_sub == BAR_SUB_LAST) begin
                bar_sub <= '0;
                if (bar_idx != 3'd7) begin
                    bar_idx <= bar_idx + 3'd1;
                end
            end else begin
                bar_sub <= bar_sub + 1'b1;
            end
        end
    end

    always_comb begin
        stage0      = '0;
        stage0.hs   = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
        stage0.vs   = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);
        stage0.vis  = (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
        stage0.hc   = h[CHECK_LOG2];
        stage0.vc   = v[CHECK_LOG2];
        stage0.bar  = bar_idx;
        stage0.h0   = (h == '0);
        stage0.v0   = (v == '0);
        stage0.mode = mode_latched;
    end

    // The mode travels with each pixel so a frame boundary never mixes two patterns.
    always_ff @(posedge VGA_CLK) begin
        if (!VGA_RST_N) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                dly[i] <= '0;
            end
        end else begin
            dly[0] <= stage0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    always_comb begin
        color    = '0;
        bar_bits = 3'b000;
        case (last.bar)
            3'd0:    bar_bits = 3'b111;
            3'd1:    bar_bits = 3'b110;
            3'd2:    bar_bits = 3'b011;
            3'd3:    bar_bits = 3'b010;
            3'd4:    bar_bits = 3'b101;
            3'd5:    bar_bits = 3'b100;
            3'd6:    bar_bits = 3'b001;
            default: bar_bits = 3'b000;
        endcase
        if (last.vis) begin
            case (last.mode)
                2'd0:    color = pix.PIX_DATA;
                2'd1:    color = SOLID_RGB;
                2'd2:    color = {{CB{bar_bits[2]}}, {CB{bar_bits[1]}}, {CB{bar_bits[0]}}};
                default: color = (last.hc ^ last.vc) ? '1 : '0;
            endcase
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (!VGA_RST_N) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= ~HSYNC_POLARITY;
            VGA_VS      <= ~VSYNC_POLARITY;
            FRAME_START <= 1'b0;
            LINE_START  <= 1'b0;
        end else begin
            VGA_R       <= color[3*CB-1 -: CB];
            VGA_G       <= color[2*CB-1 -: CB];
            VGA_B       <= color[CB-1:0];
            VGA_HS      <= last.hs ? HSYNC_POLARITY : ~HSYNC_POLARITY;
            VGA_VS      <= last.vs ? VSYNC_POLARITY : ~VSYNC_POLARITY;
            FRAME_START <= last.h0 && last.v0;
            LINE_START  <= last.h0;
        end
    end
endmodule
